// File: rtl/imem_wb_loader.sv
// Wishbone slave that loads (and, with IMEM_READBACK_EN defined, reads back) the
// SLRV instruction SRAM through port 0 and owns the core reset/fetch-enable controls.
module imem_wb_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          ADDR_W    = 9,
    parameter int          READ_WAIT = 1
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic              sram_csb0,
    output logic              sram_web0,
    output logic [3:0]        sram_wmask0,
    output logic [ADDR_W-1:0] sram_addr0,
    output logic [31:0]       sram_din0,
    input  logic [31:0]       sram_dout0,
    output logic              core_reset,
    output logic              core_imem_en
);

    // Handshake: a request is cyc&stb seen in IDLE; ack is a one-cycle pulse with
    // dat_o valid only while ack is high; the master holds the request until ack.
    if (READ_WAIT < 1 || READ_WAIT > 3) begin : gReadWaitRange
        $error("READ_WAIT must be in 1..3");
    end

`ifdef IMEM_READBACK_EN
    typedef enum logic [2:0] {IDLE, WR, RD, RWAIT, ACK} stateT;
    logic [1:0] waitCnt;
`else
    typedef enum logic [2:0] {IDLE, WR, ACK} stateT;
    logic [31:0] unusedDout;
    assign unusedDout = sram_dout0;
`endif

    stateT       state;
    logic [2:0]  ctrl;
    logic [15:0] wordCount;
    logic        dropFlag;
    logic [31:0] offset;
    logic        request;
    logic        inWindow;
    logic        isCtrl;
    logic        isStatus;
    logic [31:0] statusVal;

    assign offset    = wbs_adr_i - BASE_ADDR;
    assign request   = wbs_cyc_i & wbs_stb_i;
    assign inWindow  = (offset >> (ADDR_W + 2)) == 32'd0;
    assign isCtrl    = offset == 32'h0000_1000;
    assign isStatus  = offset == 32'h0000_1004;
    assign statusVal = {15'd0, dropFlag, wordCount};

    assign core_reset   = ctrl[0];
    assign core_imem_en = ctrl[1];

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state       <= IDLE;
            ctrl        <= 3'b101;
            wordCount   <= 16'd0;
            dropFlag    <= 1'b0;
            wbs_ack_o   <= 1'b0;
            wbs_dat_o   <= 32'd0;
            sram_csb0   <= 1'b1;
            sram_web0   <= 1'b1;
            sram_wmask0 <= 4'd0;
            sram_addr0  <= '0;
            sram_din0   <= 32'd0;
`ifdef IMEM_READBACK_EN
            waitCnt     <= 2'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (request) begin
                        if (inWindow) begin
                            if (wbs_we_i) begin
                                if (ctrl[2]) begin
                                    state       <= WR;
                                    sram_csb0   <= 1'b0;
                                    sram_web0   <= 1'b0;
                                    sram_wmask0 <= wbs_sel_i;
                                    sram_addr0  <= offset[ADDR_W+1:2];
                                    sram_din0   <= wbs_dat_i;
                                end else begin
                                    // Loading is locked out: acknowledge but remember the loss.
                                    dropFlag  <= 1'b1;
                                    state     <= ACK;
                                    wbs_ack_o <= 1'b1;
                                    wbs_dat_o <= 32'd0;
                                end
                            end else begin
`ifdef IMEM_READBACK_EN
                                state      <= RD;
                                sram_csb0  <= 1'b0;
                                sram_web0  <= 1'b1;
                                sram_addr0 <= offset[ADDR_W+1:2];
`else
                                state     <= ACK;
                                wbs_ack_o <= 1'b1;
                                wbs_dat_o <= 32'd0;
`endif
                            end
                        end else if (isCtrl) begin
                            if (wbs_we_i) begin
                                ctrl <= wbs_dat_i[2:0];
                            end
                            wbs_dat_o <= wbs_we_i ? 32'd0 : {29'd0, ctrl};
                            wbs_ack_o <= 1'b1;
                            state     <= ACK;
                        end else if (isStatus) begin
                            if (wbs_we_i) begin
                                wordCount <= 16'd0;
                                dropFlag  <= 1'b0;
                            end
                            wbs_dat_o <= wbs_we_i ? 32'd0 : statusVal;
                            wbs_ack_o <= 1'b1;
                            state     <= ACK;
                        end
                    end
                end
                WR: begin
                    sram_csb0   <= 1'b1;
                    sram_web0   <= 1'b1;
                    sram_wmask0 <= 4'd0;
                    wordCount   <= wordCount + 16'd1;
                    if (wbs_cyc_i) begin
                        state     <= ACK;
                        wbs_ack_o <= 1'b1;
                        wbs_dat_o <= 32'd0;
                    end else begin
                        state <= IDLE;
                    end
                end
`ifdef IMEM_READBACK_EN
                RD: begin
                    sram_csb0 <= 1'b1;
                    sram_web0 <= 1'b1;
                    waitCnt   <= 2'(READ_WAIT - 1);
                    state     <= wbs_cyc_i ? RWAIT : IDLE;
                end
                RWAIT: begin
                    if (!wbs_cyc_i) begin
                        state <= IDLE;
                    end else if (waitCnt == 2'd0) begin
                        wbs_dat_o <= sram_dout0;
                        wbs_ack_o <= 1'b1;
                        state     <= ACK;
                    end else begin
                        waitCnt <= waitCnt - 2'd1;
                    end
                end
`endif
                ACK: begin
                    wbs_ack_o <= 1'b0;
                    wbs_dat_o <= 32'd0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
